alu_md_unit: RTL

- Execute-stage arithmetic unit for the pipeline, parametrised in datapath width.
- Keeps the existing 5-bit ALU control encoding and branch-condition evaluation. Adds a registered result stage, a valid/ready handshake, and an iterative radix-2 multiplier/divider with architectural HI/LO registers.
- The hazard unit stalls ID/EX while in_ready is low.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_md_iter.sv | 87 ++++++++
 rtl/alu_md_unit.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU: control codes, branch opcodes,
// and the multiply/divide sequencing states.
package alu_pkg;

    localparam logic [4:0] ALU_AND  = 5'b00000;
    localparam logic [4:0] ALU_OR   = 5'b00001;
    localparam logic [4:0] ALU_ADD  = 5'b00010;
    localparam logic [4:0] ALU_SUB  = 5'b00110;
    localparam logic [4:0] ALU_SLT  = 5'b00111;
    localparam logic [4:0] ALU_NOR  = 5'b01100;
    localparam logic [4:0] ALU_XOR  = 5'b01101;
    localparam logic [4:0] ALU_SLL  = 5'b10000;
    localparam logic [4:0] ALU_SRL  = 5'b11000;
    localparam logic [4:0] ALU_SRA  = 5'b11001;
    localparam logic [4:0] ALU_MULT = 5'b10100;
    localparam logic [4:0] ALU_DIV  = 5'b10101;
    localparam logic [4:0] ALU_MFHI = 5'b10110;
    localparam logic [4:0] ALU_MFLO = 5'b10111;
    localparam logic [4:0] ALU_MTHI = 5'b11100;
    localparam logic [4:0] ALU_MTLO = 5'b11101;

    localparam logic [5:0] OP_BLTZ = 6'h01;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_BLEZ = 6'h06;
    localparam logic [5:0] OP_BGTZ = 6'h07;

    typedef enum logic [2:0] {
        StIdle,
        StMul,
        StDiv,
        StFix,
        StDone
    } md_state_e;

endpackage

// File: rtl/alu_md_iter.sv
// Iterative radix-2 unsigned multiply (shift-add) / restoring divide datapath.
// Runs WIDTH steps after start, then strobes done for one cycle.
module alu_md_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam int unsigned CntW = $clog2(WIDTH);

    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] b_q;
    logic [CntW-1:0]  cnt_q;
    logic             run_q;
    logic             div_q;
    logic             done_q;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] diff;

    // hi holds the running partial product / remainder; lo holds the
    // multiplier being consumed or the dividend shifting out as quotient shifts in.
    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        rem_sh  = {hi_q, lo_q[WIDTH-1]};
        diff    = {1'b0, rem_sh} - {2'b00, b_q};
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (div_q) begin
            if (!diff[WIDTH+1]) begin
                hi_d = diff[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = rem_sh[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_d = mul_sum[WIDTH:1];
            lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi_q   <= '0;
            lo_q   <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            div_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                hi_q  <= '0;
                lo_q  <= op_a;
                b_q   <= op_b;
                cnt_q <= '0;
                run_q <= 1'b1;
                div_q <= is_div;
            end else if (run_q) begin
                hi_q  <= hi_d;
                lo_q  <= lo_d;
                cnt_q <= cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done   = done_q;
    assign res_hi = hi_q;
    assign res_lo = lo_q;

endmodule

// File: rtl/alu_md_unit.sv
// Execute-stage ALU with registered result, valid/ready handshake, branch
// evaluation and an iterative multiply/divide unit writing HI/LO.
module alu_md_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       alu_ctl,
    input  logic [5:0]       opcode,
    input  logic             sign,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic             branch_taken,
    output logic             busy
);

    md_state_e        state_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic [WIDTH-1:0] out_q;
    logic             out_valid_q;
    logic             branch_q;
    logic             is_div_q;
    logic             neg_q;
    logic             neg_rem_q;
    logic             div_zero_q;
    logic [WIDTH-1:0] a_raw_q;

    logic             accept;
    logic             md_start;
    logic             md_done;
    logic [WIDTH-1:0] md_hi, md_lo;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] alu_res;
    logic             branch_cond;
    logic [SHAMT_W-1:0] shamt;
    logic [2*WIDTH-1:0] prod_raw, prod_fix;
    logic [WIDTH-1:0] quot_fix, rem_fix;

    assign in_ready = (state_q == StIdle);
    assign busy     = (state_q != StIdle);
    assign accept   = in_valid && in_ready;
    assign md_start = accept && ((alu_ctl == ALU_MULT) || (alu_ctl == ALU_DIV));

    assign a_neg = sign & in_a[WIDTH-1];
    assign b_neg = sign & in_b[WIDTH-1];
    assign a_mag = a_neg ? (~in_a + 1'b1) : in_a;
    assign b_mag = b_neg ? (~in_b + 1'b1) : in_b;
    assign shamt = in_a[SHAMT_W-1:0];

    always_comb begin
        alu_res = '0;
        case (alu_ctl)
            ALU_AND:  alu_res = in_a & in_b;
            ALU_OR:   alu_res = in_a | in_b;
            ALU_ADD:  alu_res = in_a + in_b;
            ALU_SUB:  alu_res = in_a - in_b;
            ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}},
                                 sign ? ($signed(in_a) < $signed(in_b)) : (in_a < in_b)};
            ALU_NOR:  alu_res = ~(in_a | in_b);
            ALU_XOR:  alu_res = in_a ^ in_b;
            ALU_SLL:  alu_res = in_b << shamt;
            ALU_SRL:  alu_res = in_b >> shamt;
            ALU_SRA:  alu_res = $signed(in_b) >>> shamt;
            ALU_MFHI: alu_res = hi_q;
            ALU_MFLO: alu_res = lo_q;
            ALU_MTHI: alu_res = in_a;
            ALU_MTLO: alu_res = in_a;
            default:  alu_res = '0;
        endcase
    end

    always_comb begin
        branch_cond = 1'b0;
        case (opcode)
            OP_BEQ:  branch_cond = (in_a == in_b);
            OP_BNE:  branch_cond = (in_a != in_b);
            OP_BLTZ: branch_cond = in_a[WIDTH-1];
            OP_BLEZ: branch_cond = in_a[WIDTH-1] || (in_a == '0);
            OP_BGTZ: branch_cond = !in_a[WIDTH-1] && (in_a != '0);
            default: branch_cond = 1'b0;
        endcase
    end

    // Sign correction of the unsigned iterative result.
    assign prod_raw = {md_hi, md_lo};
    assign prod_fix = neg_q ? (~prod_raw + 1'b1) : prod_raw;
    assign quot_fix = neg_q ? (~md_lo + 1'b1) : md_lo;
    assign rem_fix  = neg_rem_q ? (~md_hi + 1'b1) : md_hi;

    alu_md_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (md_start),
        .is_div  (alu_ctl == ALU_DIV),
        .op_a    (a_mag),
        .op_b    (b_mag),
        .done    (md_done),
        .res_hi  (md_hi),
        .res_lo  (md_lo)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            hi_q        <= '0;
            lo_q        <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            branch_q    <= 1'b0;
            is_div_q    <= 1'b0;
            neg_q       <= 1'b0;
            neg_rem_q   <= 1'b0;
            div_zero_q  <= 1'b0;
            a_raw_q     <= '0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (md_start) begin
                            state_q    <= (alu_ctl == ALU_DIV) ? StDiv : StMul;
                            is_div_q   <= (alu_ctl == ALU_DIV);
                            neg_q      <= a_neg ^ b_neg;
                            neg_rem_q  <= a_neg;
                            div_zero_q <= (in_b == '0);
                            a_raw_q    <= in_a;
                        end else begin
                            out_q       <= alu_res;
                            branch_q    <= branch_cond;
                            out_valid_q <= 1'b1;
                            if (alu_ctl == ALU_MTHI) hi_q <= in_a;
                            if (alu_ctl == ALU_MTLO) lo_q <= in_a;
                        end
                    end
                end
                StMul, StDiv: begin
                    if (md_done) state_q <= StFix;
                end
                StFix: begin
                    if (!is_div_q) begin
                        {hi_q, lo_q} <= prod_fix;
                    end else if (div_zero_q) begin
                        lo_q <= '1;
                        hi_q <= a_raw_q;
                    end else begin
                        lo_q <= quot_fix;
                        hi_q <= rem_fix;
                    end
                    state_q <= StDone;
                end
                StDone: begin
                    out_q       <= lo_q;
                    branch_q    <= 1'b0;
                    out_valid_q <= 1'b1;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign out_valid    = out_valid_q;
    assign out          = out_q;
    assign branch_taken = branch_q;

endmodule
